// File: rtl/apb_i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_i2c_pkg                                                                |
// | Register offsets, interrupt bit indices and register-select decode for     |
// | the FIFO-based APB front end of the I2C master.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package apb_i2c_pkg;

  localparam logic [7:0] OFF_ADDR     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_TXDATA   = 8'h08;
  localparam logic [7:0] OFF_RXDATA   = 8'h0C;
  localparam logic [7:0] OFF_CNT      = 8'h10;
  localparam logic [7:0] OFF_CTRL     = 8'h18;
  localparam logic [7:0] OFF_INT_STAT = 8'h20;
  localparam logic [7:0] OFF_INT_EN   = 8'h24;
  localparam logic [7:0] OFF_TIMEOUT  = 8'h28;
  localparam logic [7:0] OFF_LEVEL    = 8'h2C;
  localparam logic [7:0] OFF_WMARK    = 8'h30;

  localparam int INT_W       = 6;
  localparam int INT_CMD     = 0;
  localparam int INT_READY   = 1;
  localparam int INT_ERR     = 2;
  localparam int INT_TX_LOW  = 3;
  localparam int INT_RX_HIGH = 4;
  localparam int INT_RX_OVF  = 5;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_ADDR, SEL_STATUS, SEL_TXDATA, SEL_RXDATA, SEL_CNT,
    SEL_CTRL, SEL_INT_STAT, SEL_INT_EN, SEL_TIMEOUT, SEL_LEVEL, SEL_WMARK
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (off)
      OFF_ADDR:     sel = SEL_ADDR;
      OFF_STATUS:   sel = SEL_STATUS;
      OFF_TXDATA:   sel = SEL_TXDATA;
      OFF_RXDATA:   sel = SEL_RXDATA;
      OFF_CNT:      sel = SEL_CNT;
      OFF_CTRL:     sel = SEL_CTRL;
      OFF_INT_STAT: sel = SEL_INT_STAT;
      OFF_INT_EN:   sel = SEL_INT_EN;
      OFF_TIMEOUT:  sel = SEL_TIMEOUT;
      OFF_LEVEL:    sel = SEL_LEVEL;
      OFF_WMARK:    sel = SEL_WMARK;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_byte_fifo                                                              |
// | Synchronous FIFO with concurrent push/pop at any level; DEPTH power of 2.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the slot a full-level push needs, so both may proceed.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/apb_i2c_regif_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_i2c_regif_fifo                                                         |
// | APB register front end for the I2C master with TX/RX byte FIFOs, sticky   |
// | W1C interrupts and PSLVERR. APB_I2C_PSTRB_EN adds byte-lane strobes.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_i2c_regif_fifo
  import apb_i2c_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TOUT_W   = 20
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
`ifdef APB_I2C_PSTRB_EN
  input  logic [3:0]        PSTRB,
`endif
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PINT,
  output logic [7:0]        tx_addr,
  output logic [7:0]        tx_byte_cnt,
  output logic [15:0]       tx_ctrl,
  output logic [TOUT_W-1:0] time_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [7:0]        status,
  input  logic              error,
  output logic              i2c_ready
);

  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int RX_LW = $clog2(RX_DEPTH) + 1;

  logic [3:0]  strb;
`ifdef APB_I2C_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = 4'hF;
`endif

  logic [31:0] wmask;
  logic        access, wr, rd, err, wr_ok;
  reg_sel_e    sel;

  logic [7:0]        addr_q, addr_d, cnt_q, cnt_d, tx_wm_q, tx_wm_d, rx_wm_q, rx_wm_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [INT_W-1:0]  int_stat_q, int_stat_d, int_en_q, int_en_d, int_set, w1c, int_live;
  logic              pint_q, pint_d, ready_q, ready_d;
  logic              cmd_prev_q, cmd_prev_d, rdy_prev_q, rdy_prev_d, err_prev_q, err_prev_d;

  logic             tx_full, tx_empty, tx_push;
  logic [TX_LW-1:0] tx_level;
  logic             rx_full, rx_empty, rx_pop;
  logic [RX_LW-1:0] rx_level;
  logic [7:0]       rx_head;
  logic [31:0]      rdata;

  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign rd     = access & ~PWRITE;
  assign wmask  = lane_mask(strb);
  assign sel    = (PADDR[ADDR_W-1:8] != '0) ? SEL_NONE : decode_offset({PADDR[7:2], 2'b00});

  always_comb begin
    err = 1'b0;
    if (access) begin
      case (sel)
        SEL_NONE:              err = 1'b1;
        SEL_STATUS, SEL_LEVEL: err = PWRITE;
        SEL_RXDATA:            err = PWRITE | rx_empty;
        SEL_TXDATA:            err = ~PWRITE | tx_full;
        default:               err = 1'b0;
      endcase
    end
  end

  assign wr_ok   = wr & ~err;
  assign tx_push = wr_ok & (sel == SEL_TXDATA) & strb[0];
  assign rx_pop  = rd & ~err & (sel == SEL_RXDATA);

  i2c_byte_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk(PCLK), .rst_n(PRESETn),
    .push(tx_push), .push_data(PWDATA[7:0]),
    .pop(tx_ready), .pop_data(tx_data),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  i2c_byte_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk(PCLK), .rst_n(PRESETn),
    .push(rx_valid), .push_data(rx_data),
    .pop(rx_pop), .pop_data(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // Watermark bits are live views of the FIFO levels; only the others are stored.
  always_comb begin
    int_live              = int_stat_q;
    int_live[INT_TX_LOW]  = (8'(tx_level) <= tx_wm_q);
    int_live[INT_RX_HIGH] = (rx_wm_q != 8'd0) && (8'(rx_level) >= rx_wm_q);
  end

  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    tout_d   = tout_q;
    int_en_d = int_en_q;
    tx_wm_d  = tx_wm_q;
    rx_wm_d  = rx_wm_q;
    w1c      = '0;
    if (wr_ok) begin
      case (sel)
        SEL_ADDR:     addr_d   = (addr_q & ~wmask[7:0]) | (PWDATA[7:0] & wmask[7:0]);
        SEL_CNT:      cnt_d    = (cnt_q & ~wmask[7:0]) | (PWDATA[7:0] & wmask[7:0]);
        SEL_CTRL:     ctrl_d   = (ctrl_q & ~wmask[15:0]) | (PWDATA[15:0] & wmask[15:0]);
        SEL_TIMEOUT:  tout_d   = (tout_q & ~wmask[TOUT_W-1:0]) | (PWDATA[TOUT_W-1:0] & wmask[TOUT_W-1:0]);
        SEL_INT_EN:   int_en_d = (int_en_q & ~wmask[INT_W-1:0]) | (PWDATA[INT_W-1:0] & wmask[INT_W-1:0]);
        SEL_INT_STAT: w1c      = PWDATA[INT_W-1:0] & wmask[INT_W-1:0];
        SEL_WMARK: begin
          tx_wm_d = (tx_wm_q & ~wmask[7:0]) | (PWDATA[7:0] & wmask[7:0]);
          rx_wm_d = (rx_wm_q & ~wmask[23:16]) | (PWDATA[23:16] & wmask[23:16]);
        end
        default: ;
      endcase
    end

    cmd_prev_d = |status[3:0];
    rdy_prev_d = ready_q;
    err_prev_d = error;

    int_set             = '0;
    int_set[INT_CMD]    = cmd_prev_d & ~cmd_prev_q;
    int_set[INT_READY]  = ready_q & ~rdy_prev_q;
    int_set[INT_ERR]    = error & ~err_prev_q;
    int_set[INT_RX_OVF] = rx_valid & rx_full & ~rx_pop;

    // Set wins over a coincident W1C.
    int_stat_d              = (int_stat_q & ~w1c) | int_set;
    int_stat_d[INT_TX_LOW]  = 1'b0;
    int_stat_d[INT_RX_HIGH] = 1'b0;

    ready_d = status[1] ? 1'b0 : (ctrl_q[11] ? 1'b1 : ready_q);
    pint_d  = |(int_live & int_en_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      tout_q     <= '0;
      int_en_q   <= '0;
      int_stat_q <= '0;
      tx_wm_q    <= 8'd0;
      rx_wm_q    <= 8'd1;
      pint_q     <= 1'b0;
      ready_q    <= 1'b0;
      cmd_prev_q <= 1'b0;
      rdy_prev_q <= 1'b0;
      err_prev_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      tout_q     <= tout_d;
      int_en_q   <= int_en_d;
      int_stat_q <= int_stat_d;
      tx_wm_q    <= tx_wm_d;
      rx_wm_q    <= rx_wm_d;
      pint_q     <= pint_d;
      ready_q    <= ready_d;
      cmd_prev_q <= cmd_prev_d;
      rdy_prev_q <= rdy_prev_d;
      err_prev_q <= err_prev_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_ADDR:     rdata[7:0]        = addr_q;
      SEL_STATUS:   rdata[8:0]        = {error, status};
      SEL_RXDATA:   rdata[7:0]        = rx_head;
      SEL_CNT:      rdata[7:0]        = cnt_q;
      SEL_CTRL:     rdata[15:0]       = ctrl_q;
      SEL_INT_STAT: rdata[INT_W-1:0]  = int_live;
      SEL_INT_EN:   rdata[INT_W-1:0]  = int_en_q;
      SEL_TIMEOUT:  rdata[TOUT_W-1:0] = tout_q;
      SEL_LEVEL: begin
        rdata[7:0]   = 8'(tx_level);
        rdata[23:16] = 8'(rx_level);
      end
      SEL_WMARK: begin
        rdata[7:0]   = tx_wm_q;
        rdata[23:16] = rx_wm_q;
      end
      default: rdata = '0;
    endcase
  end

  assign PRDATA      = (rd & ~err) ? rdata : 32'd0;
  assign PSLVERR     = err;
  assign PREADY      = 1'b1;
  assign PINT        = pint_q;
  assign i2c_ready   = ready_q;
  assign tx_addr     = addr_q;
  assign tx_byte_cnt = cnt_q;
  assign tx_ctrl     = ctrl_q;
  assign time_out    = tout_q;
  assign tx_valid    = ~tx_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_regif_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_i2c_regif_fifo                                                      |
// | Directed self-checking bench for apb_i2c_regif_fifo (default parameters).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_apb_i2c_regif_fifo;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, PINT;
  logic [7:0]  tx_addr, tx_byte_cnt, tx_data;
  logic [15:0] tx_ctrl;
  logic [19:0] time_out;
  logic        tx_valid, i2c_ready;
  logic        tx_ready = 1'b0, rx_valid = 1'b0, error = 1'b0;
  logic [7:0]  rx_data = '0, status = '0;

  int n_pass = 0;
  int n_total = 0;

  apb_i2c_regif_fifo dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_I2C_PSTRB_EN
    .PSTRB(4'hF),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PINT(PINT),
    .tx_addr(tx_addr), .tx_byte_cnt(tx_byte_cnt), .tx_ctrl(tx_ctrl),
    .time_out(time_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .status(status), .error(error), .i2c_ready(i2c_ready)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // One APB transfer; perr drives the core error input during the access phase.
  task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic perr, output logic [31:0] rdat, output logic se);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; error = perr;
    #3;
    rdat = PRDATA; se = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; error = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] d, input logic exp_se);
    logic [31:0] r; logic se;
    apb(1'b1, a, d, 1'b0, r, se);
    check(tag, {31'd0, se}, {31'd0, exp_se});
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic exp_se);
    logic [31:0] r; logic se;
    apb(1'b0, a, 32'd0, 1'b0, r, se);
    check(tag, r, exp);
    check({tag, "_err"}, {31'd0, se}, {31'd0, exp_se});
  endtask

  initial begin
    logic [31:0] r;
    logic        se;

    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    check("rst_pint", {31'd0, PINT}, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_ready", {31'd0, i2c_ready}, 32'd0);
    check("rst_txvalid", {31'd0, tx_valid}, 32'd0);
    rd_chk("rst_level", 12'h02C, 32'h0000_0000, 1'b0);
    rd_chk("rst_wmark", 12'h030, 32'h0001_0000, 1'b0);
    rd_chk("rst_intstat", 12'h020, 32'h0000_0008, 1'b0);

    // Fill TX past capacity; core not popping.
    for (int i = 0; i < 9; i++)
      wr_chk("tx_push", 12'h008, 32'hA0 + i, (i == 8));
    rd_chk("tx_level", 12'h02C, 32'h0000_0008, 1'b0);

    // Overflow RX by one byte.
    @(posedge PCLK); #1;
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(i + 1);
      @(posedge PCLK); #1;
    end
    rx_valid = 1'b0;
    rd_chk("ovf_intstat", 12'h020, 32'h0000_0030, 1'b0);
    rd_chk("both_level", 12'h02C, 32'h0008_0008, 1'b0);

    wr_chk("inten_wr", 12'h024, 32'h20, 1'b0);
    check("pint_lat0", {31'd0, PINT}, 32'd0);
    @(posedge PCLK); #1;
    check("pint_set", {31'd0, PINT}, 32'd1);
    wr_chk("w1c_ovf", 12'h020, 32'h20, 1'b0);
    check("pint_hold", {31'd0, PINT}, 32'd1);
    @(posedge PCLK); #1;
    check("pint_clr", {31'd0, PINT}, 32'd0);
    rd_chk("after_w1c", 12'h020, 32'h0000_0010, 1'b0);

    for (int i = 0; i < 8; i++)
      rd_chk("rx_pop", 12'h00C, 32'(i + 1), 1'b0);
    rd_chk("rx_empty", 12'h00C, 32'd0, 1'b1);
    rd_chk("rx_drained_int", 12'h020, 32'h0000_0000, 1'b0);

    // Drain TX with tx_ready held.
    @(posedge PCLK); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_head", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'(8'hA0 + i)});
      @(posedge PCLK); #1;
    end
    check("tx_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    rd_chk("txlow_int", 12'h020, 32'h0000_0008, 1'b0);

    // Error edge coinciding with W1C of the same bit: set wins.
    apb(1'b1, 12'h020, 32'h04, 1'b1, r, se);
    check("err_w1c_se", {31'd0, se}, 32'd0);
    rd_chk("err_setwins", 12'h020, 32'h0000_000C, 1'b0);
    wr_chk("err_w1c", 12'h020, 32'h04, 1'b0);
    rd_chk("err_cleared", 12'h020, 32'h0000_0008, 1'b0);

    wr_chk("ctrl_wr", 12'h018, 32'h0000_0800, 1'b0);
    check("ready_lat", {31'd0, i2c_ready}, 32'd0);
    @(posedge PCLK); #1;
    check("ready_set", {31'd0, i2c_ready}, 32'd1);
    rd_chk("ready_int", 12'h020, 32'h0000_000A, 1'b0);
    rd_chk("ctrl_rd", 12'h018, 32'h0000_0800, 1'b0);
    status = 8'h02;
    @(posedge PCLK); #1;
    check("ready_clrwins", {31'd0, i2c_ready}, 32'd0);
    status = 8'h00;
    @(posedge PCLK); #1;
    check("ready_reset", {31'd0, i2c_ready}, 32'd1);
    rd_chk("cmd_int", 12'h020, 32'h0000_000B, 1'b0);

    wr_chk("addr_wr", 12'h000, 32'hFFFF_FF5A, 1'b0);
    rd_chk("addr_rd", 12'h000, 32'h0000_005A, 1'b0);
    check("tx_addr", {24'd0, tx_addr}, 32'h5A);
    wr_chk("cnt_wr", 12'h010, 32'h1234_56C3, 1'b0);
    rd_chk("cnt_rd", 12'h010, 32'h0000_00C3, 1'b0);
    check("tx_byte_cnt", {24'd0, tx_byte_cnt}, 32'hC3);
    wr_chk("tout_wr", 12'h028, 32'hFFFF_FFFF, 1'b0);
    rd_chk("tout_rd", 12'h028, 32'h000F_FFFF, 1'b0);
    check("time_out", {12'd0, time_out}, 32'h000F_FFFF);
    wr_chk("wmark_wr", 12'h030, 32'h1203_0002, 1'b0);
    rd_chk("wmark_rd", 12'h030, 32'h0003_0002, 1'b0);

    wr_chk("wr_status", 12'h004, 32'hFF, 1'b1);
    wr_chk("wr_level", 12'h02C, 32'hFF, 1'b1);
    wr_chk("wr_rxdata", 12'h00C, 32'hFF, 1'b1);
    rd_chk("rd_txdata", 12'h008, 32'd0, 1'b1);
    rd_chk("rd_unmapped", 12'h040, 32'd0, 1'b1);
    rd_chk("rd_hole", 12'h014, 32'd0, 1'b1);
    wr_chk("wr_unmapped", 12'h040, 32'h77, 1'b1);
    wr_chk("wr_upper", 12'h400, 32'h77, 1'b1);
    rd_chk("addr_kept", 12'h000, 32'h0000_005A, 1'b0);
    rd_chk("level_kept", 12'h02C, 32'h0000_0000, 1'b0);

    status = 8'hA4;
    apb(1'b0, 12'h004, 32'd0, 1'b1, r, se);
    check("status_rd", r, 32'h0000_01A4);
    check("status_se", {31'd0, se}, 32'd0);
    status = 8'h00;
    check("pint_final", {31'd0, PINT}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
